// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for an 8-digit common-anode 7-segment
//            display. Shows a 32-bit value as 8 hex digits. The value is
//            sampled once per frame so every digit of a frame comes from the
//            same snapshot. The first BLANK cycles of each digit slot keep
//            all anodes off to suppress ghosting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   value      in  32  value to display, nibble k -> digit k (0 = rightmost)
//   dp_mask    in   8  decimal point enable per digit, bit k -> digit k
//   hold       in   1  1 = keep the current snapshot at frame start
//   an         out  8  digit anodes, active-low, an[k] = digit k
//   seg        out  7  segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp         out  1  decimal point cathode, active-low
//   frame_tick out  1  one-cycle pulse at the start of every frame
// ----------------------------------------------------------------------------
// Parameters
//   PRESCALE   clk cycles per digit slot, must be >= 2
//   BLANK      blanked cycles at the start of each slot, 1 <= BLANK < PRESCALE
// ----------------------------------------------------------------------------
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, digits above the highest
//                               nonzero nibble of the snapshot stay dark.
//                               Digit 0 is always shown.
// ============================================================================
module seg7_scan_driver #(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned c_PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [c_PW-1:0] c_PMAX  = c_PW'(PRESCALE - 1);
  localparam logic [c_PW-1:0] c_BLANK = c_PW'(BLANK);
  localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);

  localparam logic [7:0] c_AN_OFF  = 8'hFF;
  localparam logic [6:0] c_SEG_OFF = 7'h7F;

  // --------------------------------------------------------------------------
  // Hex to segment map, active-high, bit order gfedcba
  // --------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] r_p;          // cycle within the current digit slot
  logic [2:0]      r_i;          // digit currently being scanned
  logic [31:0]     r_snap_val;   // frame-coherent copy of value
  logic [7:0]      r_snap_dp;    // frame-coherent copy of dp_mask
  logic [7:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_frame_tick;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic            w_slot_end;
  logic            w_frame_start;
  logic            w_snap_load;
  logic            w_active;
  logic            w_show;
  logic [3:0]      w_nib;
  logic [6:0]      w_hex;
  logic [7:0]      w_an_nxt;
  logic [6:0]      w_seg_nxt;
  logic            w_dp_nxt;

  assign w_slot_end    = (r_p == c_PMAX);
  assign w_frame_start = (r_p == '0) && (r_i == 3'd0);
  assign w_snap_load   = w_frame_start && !hold;

  // The snapshot changes on the edge that ends p==0 of digit 0. Output for
  // that slot stays blank until p reaches BLANK (>= 1), so the swap is never
  // visible part-way through a digit.
  assign w_active      = (r_p >= c_BLANK);

  assign w_nib         = r_snap_val[{r_i, 2'b00} +: 4];
  assign w_hex         = hex_to_seg(w_nib);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Highest nonzero nibble of the snapshot; stays 0 for an all-zero value
  // so digit 0 is always lit.
  logic [2:0] w_h;

  always_comb begin
    w_h = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_snap_val[4*k +: 4] != 4'h0) begin
        w_h = 3'(k);
      end
    end
  end

  assign w_show = (r_i <= w_h);
`else
  assign w_show = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Next output value, registered below for one cycle of latency
  // --------------------------------------------------------------------------
  always_comb begin
    w_an_nxt  = c_AN_OFF;
    w_seg_nxt = c_SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (w_active && w_show) begin
      w_an_nxt  = ~(8'h01 << r_i);
      w_seg_nxt = ~w_hex;
      w_dp_nxt  = ~r_snap_dp[r_i];
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and digit index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_i <= 3'd0;
    end else if (w_slot_end) begin
      r_p <= '0;
      r_i <= r_i + 3'd1;   // natural 3-bit wrap from digit 7 to digit 0
    end else begin
      r_p <= r_p + c_PONE;
    end
  end

  // --------------------------------------------------------------------------
  // Frame snapshot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_val <= 32'h0;
      r_snap_dp  <= 8'h0;
    end else if (w_snap_load) begin
      r_snap_val <= value;
      r_snap_dp  <= dp_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= c_AN_OFF;
      r_seg        <= c_SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_frame_start;   // pulses even while hold is set
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes a 32-bit value from the free-running counter (or any other 32-bit source) and displays it as 8 hex digits.
- Drives a time-multiplexed 8-digit common-anode 7-segment display.
- Samples the value once per frame so all digits in a frame show one coherent value.
- Provides per-slot anti-ghost blanking and a frame strobe for upstream logic.

Parameters:
- PRESCALE, 100000: clk cycles per digit slot; must be ≥ 2.
- BLANK, 4: cycles at the start of each slot with all anodes off; 1 ≤ BLANK < PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- value  in  32  value to display; nibble k goes to digit k (digit 0 = rightmost).
- dp_mask  in  8  decimal point enable per digit; bit k = digit k.
- hold  in  1  1 = freeze the displayed snapshot.
- an  out  8  digit anodes, active-low, an[k] = digit k.
- seg  out  7  segment cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point cathode, active-low.
- frame_tick  out  1  one-cycle pulse marking the start of a frame.

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - Reset is synchronous and active-high (rst).
- Reset values:
  - Prescaler p=0, digit index i=0.
  - Snapshots: snap_val=0, snap_dp=0.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler and digit index:
  - If p==PRESCALE-1: p←0 and i←i+1 (mod 8, so 7 wraps to 0).
  - Otherwise p←p+1.
  - One frame = 8·PRESCALE cycles.
- Snapshot:
  - Load condition: p==0 && i==0 && !hold, which is the first cycle of every frame, including the first cycle after reset.
  - On load: snap_val←value, snap_dp←dp_mask.
  - While hold=1 the snapshot is retained indefinitely.
  - Changes on value or dp_mask mid-frame never reach the display before the next frame start.
- frame_tick: registered; frame_tick←(p==0 && i==0). It pulses exactly once per frame regardless of hold.
- Outputs are registered, one cycle of latency from state (p, i, snap):
  - If p<BLANK: an=8'hFF, seg=7'h7F, dp=1.
  - Otherwise: an=~(1<<i), seg=~HEX(snap_val[4i+3:4i]), dp=~snap_dp[i].
- HEX table (gfedcba, active-high):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Blanking guarantee: since BLANK ≥ 1, the snapshot update at frame start is never visible mid-digit.
- Reset mid-frame: all state returns to reset values on the next edge. The first output cycle after rst is released is blank, and a new frame begins immediately.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined:
  - Let h = index of the highest nonzero nibble of snap_val (h=0 if snap_val==0).
  - Digits k>h keep an[k]=1 during their slot: seg=7'h7F and dp=1, even if snap_dp[k]=1.
  - Digit 0 is always shown.
  - h is computed from the snapshot, never from the live value.
- When not defined: all 8 digits are always driven per the rules above.

Test Plan (PRESCALE=8, BLANK=2):
- Reset: hold rst=1 for 3 cycles.
  - During reset: an=FF, seg=7F, dp=1, frame_tick=0.
  - frame_tick=1 in the 2nd cycle after release, then exactly every 64 cycles.
- Digit content: value=32'h1234ABCD, dp_mask=8'h01.
  - Digit-0 active cycles: an=FE, seg=7'h21, dp=0.
  - Digit-7 active cycles: an=7F, seg=7'h79, dp=1.
  - Each slot shows 2 blank cycles (an=FF) followed by 6 active cycles.
- Coherence: change value from 32'h11111111 to 32'h22222222 while digit 3 is active.
  - Digits 3..7 of the current frame still show "1" (seg=79).
  - The next frame shows "2" (seg=24) on all digits.
- Hold: set hold=1, then change value across 3 frames.
  - Display remains unchanged.
  - frame_tick still pulses every 64 cycles.
  - Deassert hold; the new value appears from the next frame start.
- Mid-frame reset: assert rst for 1 cycle while i=5, p=4.
  - Next cycle: an=FF.
  - Scanning restarts at digit 0; frame_tick follows 2 cycles after release.
- With SEG7_LEADING_ZERO_BLANK_EN and value=32'h000000A5:
  - Only an[0] and an[1] ever go low; an[7:2] stay 1.
  - With value=0, only digit 0 shows "0" (seg=40).
